clause_batch_feeder: RTL and testbench
======================================

# clause_batch_feeder

Issue side of the clause evaluator cluster. The block accepts a stream of reduced clauses (NSAT-REDUCE literal value/negation pairs each) and packs up to CLUSTER_SIZE of them into the packed value/negation buses that drive the cluster. It waits out the evaluator latency, captures the returned break vector, and presents a masked break mask and break count to the downstream pick/flip logic over a valid/ready handshake.

## Interface
- CLUSTER_SIZE, 20, clause slots per batch (matches the cluster)
- NSAT, 3, literals per clause
- REDUCE, 1, literals known unsat and not transported; W = NSAT-REDUCE literals per slot
- EVAL_LATENCY, 1, cycles from bus change to valid break_mi (1 = output-gated evaluator, 0 = combinational)
- CNT_W, $clog2(CLUSTER_SIZE+1), width of count fields

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- clause_valid_i  in  1  clause literal word present
- clause_ready_o  out  1  block accepts a clause this cycle
- clause_val_i  in  W  literal values
- clause_neg_i  in  W  literal negation flags
- clause_last_i  in  1  this clause closes the batch early
- var_val_mo  out  W*CLUSTER_SIZE  packed values to cluster; slot i at [i*W +: W]
- var_neg_mo  out  W*CLUSTER_SIZE  packed negations, same packing
- break_mi  in  CLUSTER_SIZE  break vector returned by cluster
- res_valid_o  out  1  result valid
- res_ready_i  in  1  downstream accepts result
- res_mask_o  out  CLUSTER_SIZE  break_mi masked to filled slots
- res_count_o  out  CNT_W  popcount of res_mask_o
- res_fill_o  out  CNT_W  clauses in this batch (1..CLUSTER_SIZE)

## Operation
- States: FILL, EVAL, HOLD. Reset state FILL.
- Padding literal: val=1, neg=0 (literal true, slot never breaks). All slots padded on reset and on HOLD exit.
- FILL: clause_ready_o=1. Handshake (valid&ready) writes slot fill_cnt with clause_val_i/clause_neg_i, fill_cnt increments. Go to EVAL when the accepted clause has clause_last_i=1 or fill_cnt==CLUSTER_SIZE-1; res_fill_o latches fill_cnt+1. No other transition from FILL; an empty batch is impossible.
- EVAL: clause_ready_o=0. Wait counter runs EVAL_LATENCY+1 cycles; at the edge ending the last EVAL cycle register res_mask_o = break_mi & slot_mask (bits 0..fill-1 set), res_count_o = popcount(res_mask_o), go to HOLD.
- HOLD: res_valid_o=1, clause_ready_o=0, all res_* stable. On res_ready_i=1: pad all slots, fill_cnt=0, go to FILL (res_valid_o low next cycle).
- var_*_mo are registers driven directly from slot storage; unchanged outside FILL writes and HOLD exit.
- res_count_o max value CLUSTER_SIZE; CNT_W sized so no overflow.
- Reset values: clause_ready_o=1, res_valid_o=0, res_mask_o=0, res_count_o=0, res_fill_o=0, var_val_mo all ones, var_neg_mo all zeros, fill_cnt=0.
- Reset asserted mid-FILL/EVAL/HOLD: batch discarded, no result emitted, all registers to reset values immediately (async).

## Timing
- Clause accepted in final handshake cycle c: EVAL covers c+1..c+1+EVAL_LATENCY; res_valid_o high from cycle c+2+EVAL_LATENCY (c+3 at default).
- Result handshake in cycle h: state FILL and clause_ready_o=1 in h+1; earliest next clause accept h+1.
- Minimum batch period: fill_cnt + EVAL_LATENCY + 2 cycles with no backpressure.
- clause_valid_i during EVAL/HOLD ignored (ready low); upstream holds data.
- break_mi sampled once per batch only; changes outside the sample edge have no effect.
- clause_ready_o is a decode of state only (no combinational path from any input).

## Test plan
- Full batch, EVAL_LATENCY=1: 20 clauses, slots 2,7,19 all-false literals (val==neg) -> res_valid_o at accept+3, res_mask_o=0x80084, res_count_o=3, res_fill_o=20.
- Short batch: 3 clauses, last on third, slot 1 breaking; bench model forces break_mi[10]=1 on padded slot -> res_mask_o=0x00002, count=1, fill=3; var_val_mo slots 3..19 = all ones, var_neg_mo = zeros.
- Backpressure: hold res_ready_i=0 for 5 cycles with clause_valid_i=1 -> clause_ready_o=0, res_* stable throughout; release -> FILL next cycle, next clause accepted that cycle.
- Back-to-back: batch of 20 then batch of 1 -> second batch slots 1..19 padded, res_fill_o=1, count reflects slot 0 only.
- Reset mid-EVAL: drop rst_i low in first EVAL cycle -> all outputs at reset values asynchronously, no res_valid_o pulse after release, next batch correct.
- EVAL_LATENCY=0 build, combinational cluster model: 1-clause breaking batch -> res_valid_o at accept+2, mask=0x1, count=1.

Source files
------------

// File: rtl/clause_batch_feeder_if.sv
// ---------------------------------------------------------------------------
// clause_batch_feeder_if
// Purpose : bundles the two handshake channels of the clause batch feeder:
//           the inbound clause stream and the outbound batch result.
//           Signal suffixes are written from the feeder's point of view.
// Ports   : none (signals only)
//   clause_valid_i / clause_ready_o   clause stream handshake
//   clause_val_i / clause_neg_i [W]   literal values / negation flags
//   clause_last_i                     clause closes the batch early
//   res_valid_o / res_ready_i         result handshake
//   res_mask_o [CLUSTER_SIZE]         break vector masked to filled slots
//   res_count_o / res_fill_o [CNT_W]  popcount of mask / clauses in batch
// Modports: slave  = feeder side, master = producer/consumer side
// ---------------------------------------------------------------------------
interface clause_batch_feeder_if #(
   parameter int CLUSTER_SIZE = 20,
   parameter int W            = 2,
   parameter int CNT_W        = 5
) ();
   logic                    clause_valid_i;
   logic                    clause_ready_o;
   logic [W-1:0]            clause_val_i;
   logic [W-1:0]            clause_neg_i;
   logic                    clause_last_i;
   logic                    res_valid_o;
   logic                    res_ready_i;
   logic [CLUSTER_SIZE-1:0] res_mask_o;
   logic [CNT_W-1:0]        res_count_o;
   logic [CNT_W-1:0]        res_fill_o;

   modport slave (
      input  clause_valid_i, clause_val_i, clause_neg_i, clause_last_i, res_ready_i,
      output clause_ready_o, res_valid_o, res_mask_o, res_count_o, res_fill_o
   );

   modport master (
      output clause_valid_i, clause_val_i, clause_neg_i, clause_last_i, res_ready_i,
      input  clause_ready_o, res_valid_o, res_mask_o, res_count_o, res_fill_o
   );
endinterface

// File: rtl/clause_batch_feeder.sv
// ---------------------------------------------------------------------------
// clause_batch_feeder
// Purpose : packs up to CLUSTER_SIZE reduced clauses into the value/negation
//           buses of the clause evaluator cluster, waits out the evaluator
//           latency, samples the returned break vector once, and offers the
//           masked break mask, its popcount and the batch fill downstream.
// Ports   :
//   clk_i        clock, rising edge
//   rst_i        asynchronous active-low reset
//   feed_if      clause stream in / batch result out (slave modport)
//   var_val_mo   packed literal values to cluster, slot i at [i*W +: W]
//   var_neg_mo   packed literal negations, same packing
//   break_mi     break vector returned by the cluster
// ---------------------------------------------------------------------------
module clause_batch_feeder #(
   parameter int CLUSTER_SIZE = 20,
   parameter int NSAT         = 3,
   parameter int REDUCE       = 1,
   parameter int EVAL_LATENCY = 1,
   parameter int CNT_W        = $clog2(CLUSTER_SIZE + 1)
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   clause_batch_feeder_if.slave                   feed_if,
   output logic [(NSAT-REDUCE)*CLUSTER_SIZE-1:0]  var_val_mo,
   output logic [(NSAT-REDUCE)*CLUSTER_SIZE-1:0]  var_neg_mo,
   input  logic [CLUSTER_SIZE-1:0]                break_mi
);
   localparam int W      = NSAT - REDUCE;
   localparam int BUS_W  = W * CLUSTER_SIZE;
   localparam int WAIT_W = $clog2(EVAL_LATENCY + 2);

   typedef enum logic [1:0] {FILL, EVAL, HOLD} state_e;

   state_e                  state_q, state_d;
   logic [CNT_W-1:0]        fill_cnt_q;
   logic [WAIT_W-1:0]       wait_q;
   logic [BUS_W-1:0]        var_val_q, var_neg_q;
   logic [CLUSTER_SIZE-1:0] res_mask_q;
   logic [CNT_W-1:0]        res_count_q, res_fill_q;

   logic                    accept, fill_done, eval_done, res_take;
   logic [CLUSTER_SIZE-1:0] slot_mask, masked_break;
   logic [CNT_W-1:0]        masked_count;

   assign accept    = feed_if.clause_valid_i && (state_q == FILL);
   assign fill_done = accept && (feed_if.clause_last_i ||
                                 (fill_cnt_q == CNT_W'(CLUSTER_SIZE - 1)));
   assign eval_done = (state_q == EVAL) && (wait_q == WAIT_W'(EVAL_LATENCY));
   assign res_take  = (state_q == HOLD) && feed_if.res_ready_i;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) state_q <= FILL;
      else        state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         FILL:    if (fill_done) state_d = EVAL;
         EVAL:    if (eval_done) state_d = HOLD;
         HOLD:    if (res_take)  state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // ---------------- FSM: outputs (pure state decode, no input paths) ----------------
   always_comb begin
      feed_if.clause_ready_o = 1'b0;
      feed_if.res_valid_o    = 1'b0;
      case (state_q)
         FILL:    feed_if.clause_ready_o = 1'b1;
         HOLD:    feed_if.res_valid_o    = 1'b1;
         default: ;
      endcase
   end

   // Slots below the latched fill count are live; padded slots never report.
   for (genvar gi = 0; gi < CLUSTER_SIZE; gi++) begin : g_slot_mask
      assign slot_mask[gi] = (CNT_W'(gi) < res_fill_q);
   end

   assign masked_break = break_mi & slot_mask;

   always_comb begin
      masked_count = '0;
      for (int i = 0; i < CLUSTER_SIZE; i++) begin
         masked_count = masked_count + CNT_W'(masked_break[i]);
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fill_cnt_q  <= '0;
         wait_q      <= '0;
         var_val_q   <= '1;   // padding literal: value 1, not negated -> true
         var_neg_q   <= '0;
         res_mask_q  <= '0;
         res_count_q <= '0;
         res_fill_q  <= '0;
      end else begin
         // Wait counter only runs while evaluating; restarts from 0 on entry.
         if (state_q == EVAL) wait_q <= wait_q + WAIT_W'(1);
         else                 wait_q <= '0;

         if (res_take) begin
            fill_cnt_q <= '0;
            var_val_q  <= '1;
            var_neg_q  <= '0;
         end else if (accept) begin
            fill_cnt_q                        <= fill_cnt_q + CNT_W'(1);
            var_val_q[int'(fill_cnt_q)*W +: W] <= feed_if.clause_val_i;
            var_neg_q[int'(fill_cnt_q)*W +: W] <= feed_if.clause_neg_i;
         end

         if (fill_done) res_fill_q <= fill_cnt_q + CNT_W'(1);

         // Single sample of the cluster result per batch.
         if (eval_done) begin
            res_mask_q  <= masked_break;
            res_count_q <= masked_count;
         end
      end
   end

   assign var_val_mo          = var_val_q;
   assign var_neg_mo          = var_neg_q;
   assign feed_if.res_mask_o  = res_mask_q;
   assign feed_if.res_count_o = res_count_q;
   assign feed_if.res_fill_o  = res_fill_q;

endmodule

// File: tb/tb_clause_batch_feeder.sv
// ---------------------------------------------------------------------------
// tb_clause_batch_feeder
// Purpose : self-checking bench for clause_batch_feeder. Drives batches from
//           a vector table, models the cluster (registered for the default
//           build, combinational for an EVAL_LATENCY=0 build), and checks
//           results against a scoreboard of hand-computed expectations.
// Ports   : none
// ---------------------------------------------------------------------------
module tb_clause_batch_feeder;
   localparam int CS  = 20;
   localparam int W   = 2;
   localparam int BW  = CS * W;
   localparam int CNT = 5;

   typedef struct {
      int          n;
      logic [CS-1:0] brk;    // slots given all-false literals
      logic [CS-1:0] frc;    // extra break bits forced by the cluster model
      int          stall;    // cycles res_ready_i held low
      logic [CS-1:0] mask;
      int          count;
      int          fill;
   } vec_t;

   typedef struct {
      logic [CS-1:0] mask;
      int          count;
      int          fill;
      int          vcyc;
      int          stall;
   } exp_t;

   logic clk, rst_n;
   int   cyc = 0;
   int   n_checks = 0, n_fail = 0;
   int   last_hs = 0;
   exp_t sb[$];
   vec_t tbl[6];

   logic [CS-1:0] force_bits;
   logic [BW-1:0] var_val, var_neg, var_val0, var_neg0;
   logic [CS-1:0] brk_q, break_mi, break0;

   clause_batch_feeder_if #(.CLUSTER_SIZE(CS), .W(W), .CNT_W(CNT)) feed  ();
   clause_batch_feeder_if #(.CLUSTER_SIZE(CS), .W(W), .CNT_W(CNT)) feed0 ();

   clause_batch_feeder #(.CLUSTER_SIZE(CS), .NSAT(3), .REDUCE(1), .EVAL_LATENCY(1)) dut (
      .clk_i(clk), .rst_i(rst_n), .feed_if(feed),
      .var_val_mo(var_val), .var_neg_mo(var_neg), .break_mi(break_mi));

   clause_batch_feeder #(.CLUSTER_SIZE(CS), .NSAT(3), .REDUCE(1), .EVAL_LATENCY(0)) dut0 (
      .clk_i(clk), .rst_i(rst_n), .feed_if(feed0),
      .var_val_mo(var_val0), .var_neg_mo(var_neg0), .break_mi(break0));

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Cluster model: a clause breaks when every literal is false (val == neg).
   function automatic logic [CS-1:0] brk_fn(input logic [BW-1:0] v, input logic [BW-1:0] n);
      logic [CS-1:0] r;
      for (int i = 0; i < CS; i++) r[i] = (v[i*W +: W] == n[i*W +: W]);
      return r;
   endfunction

   always @(posedge clk) brk_q <= brk_fn(var_val, var_neg);
   assign break_mi = brk_q | force_bits;
   assign break0   = brk_fn(var_val0, var_neg0);

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_clause_ready"}, feed.clause_ready_o, 1);
      chk({tag, "_res_valid"},    feed.res_valid_o, 0);
      chk({tag, "_res_mask"},     feed.res_mask_o, 0);
      chk({tag, "_res_count"},    feed.res_count_o, 0);
      chk({tag, "_res_fill"},     feed.res_fill_o, 0);
      chk({tag, "_var_val"},      var_val, {BW{1'b1}});
      chk({tag, "_var_neg"},      var_neg, 0);
   endtask

   // Called at a negedge; returns at the negedge after the clause is taken.
   task automatic send_clause(input logic [W-1:0] v, input logic [W-1:0] n,
                              input logic last, output int acc);
      int t = 0;
      feed.clause_valid_i = 1'b1;
      feed.clause_val_i   = v;
      feed.clause_neg_i   = n;
      feed.clause_last_i  = last;
      while (!feed.clause_ready_o && t < 200) begin
         @(negedge clk);
         t++;
      end
      acc = cyc;
      if (!feed.clause_ready_o) begin
         n_checks++;
         n_fail++;
         $display("FAIL clause_accept_timeout: ready stayed 0 for %0d cycles", t);
      end
      @(negedge clk);
   endtask

   task automatic send_batch(input vec_t e, input bit check_gap, input bit push);
      logic [BW-1:0] ev, en;
      logic [W-1:0]  v, nn;
      int            acc;
      exp_t          x;
      ev = '1;
      en = '0;
      for (int k = 0; k < e.n; k++) begin
         v = W'($urandom);
         if (e.brk[k]) nn = v;
         else          nn = v ^ W'($urandom_range(3, 1));
         ev[k*W +: W] = v;
         en[k*W +: W] = nn;
         send_clause(v, nn, (k == e.n - 1), acc);
         if (k == 0) begin
            if (check_gap) chk("accept_after_result", acc, last_hs + 1);
            force_bits = e.frc;
         end
      end
      chk("var_val_bus", var_val, ev);
      chk("var_neg_bus", var_neg, en);
      $display("batch n=%0d last accept cycle %0d mask=0x%05h count=%0d",
               e.n, acc, e.mask, e.count);
      if (push) begin
         x.mask  = e.mask;
         x.count = e.count;
         x.fill  = e.fill;
         x.vcyc  = acc + 3;
         x.stall = e.stall;
         sb.push_back(x);
      end
   endtask

   // Result monitor: owns res_ready_i, pops the scoreboard on handshake.
   initial begin : monitor
      int  stall_left = 0;
      bit  was_valid  = 1'b0;
      bit  hs_prev    = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            was_valid        = 1'b0;
            hs_prev          = 1'b0;
            feed.res_ready_i = 1'b0;
         end else begin
            if (hs_prev) begin
               chk("fill_after_result", feed.clause_ready_o, 1);
               chk("valid_drop_after_result", feed.res_valid_o, 0);
               hs_prev = 1'b0;
            end
            if (feed.res_valid_o) begin
               if (sb.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_result: mask=0x%0h with empty scoreboard",
                           feed.res_mask_o);
                  feed.res_ready_i = 1'b1;
               end else begin
                  if (!was_valid) begin
                     chk("res_valid_latency", cyc, sb[0].vcyc);
                     stall_left = sb[0].stall;
                  end
                  chk("res_mask",  feed.res_mask_o,  sb[0].mask);
                  chk("res_count", feed.res_count_o, sb[0].count);
                  chk("res_fill",  feed.res_fill_o,  sb[0].fill);
                  chk("ready_low_in_hold", feed.clause_ready_o, 0);
                  if (stall_left > 0) begin
                     stall_left--;
                     feed.res_ready_i = 1'b0;
                  end else begin
                     feed.res_ready_i = 1'b1;
                     last_hs = cyc;
                     hs_prev = 1'b1;
                     $display("result mask=0x%05h count=%0d fill=%0d taken cycle %0d",
                              feed.res_mask_o, feed.res_count_o, feed.res_fill_o, cyc);
                     void'(sb.pop_front());
                  end
               end
            end else begin
               feed.res_ready_i = 1'b0;
            end
            was_valid = feed.res_valid_o;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      vec_t e;
      int   acc, t;
      tbl[0] = '{n:20, brk:20'h80084, frc:20'h00000, stall:0, mask:20'h80084, count:3,  fill:20};
      tbl[1] = '{n:3,  brk:20'h00002, frc:20'h00400, stall:0, mask:20'h00002, count:1,  fill:3};
      tbl[2] = '{n:20, brk:20'hFFFFF, frc:20'h00000, stall:0, mask:20'hFFFFF, count:20, fill:20};
      tbl[3] = '{n:1,  brk:20'h00001, frc:20'hFFFFE, stall:0, mask:20'h00001, count:1,  fill:1};
      tbl[4] = '{n:5,  brk:20'h0000A, frc:20'h00000, stall:5, mask:20'h0000A, count:2,  fill:5};
      tbl[5] = '{n:7,  brk:20'h00000, frc:20'h00000, stall:2, mask:20'h00000, count:0,  fill:7};

      rst_n               = 1'b1;
      force_bits          = '0;
      feed.clause_valid_i = 1'b0;
      feed.clause_val_i   = '0;
      feed.clause_neg_i   = '0;
      feed.clause_last_i  = 1'b0;
      feed0.clause_valid_i = 1'b0;
      feed0.clause_val_i   = '0;
      feed0.clause_neg_i   = '0;
      feed0.clause_last_i  = 1'b0;
      feed0.res_ready_i    = 1'b0;

      #2 rst_n = 1'b0;
      #1 check_reset("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 6; i++) send_batch(tbl[i], (i > 0), 1'b1);

      // Reset during the first EVAL cycle: batch must vanish without a result.
      e = '{n:2, brk:20'h00003, frc:20'h00000, stall:0, mask:20'h00003, count:2, fill:2};
      send_batch(e, 1'b1, 1'b0);
      chk("in_eval_ready_low", feed.clause_ready_o, 0);
      rst_n = 1'b0;
      #1 check_reset("mid_eval_reset");
      feed.clause_valid_i = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("no_result_after_reset", feed.res_valid_o, 0);
      end
      e = '{n:4, brk:20'h00008, frc:20'h00000, stall:0, mask:20'h00008, count:1, fill:4};
      send_batch(e, 1'b0, 1'b1);
      feed.clause_valid_i = 1'b0;

      t = 0;
      while (sb.size() != 0 && t < 300) begin
         @(negedge clk);
         t++;
      end
      chk("scoreboard_drained", sb.size(), 0);

      // EVAL_LATENCY=0 build with combinational cluster: single breaking clause.
      feed0.clause_valid_i = 1'b1;
      feed0.clause_val_i   = 2'b01;
      feed0.clause_neg_i   = 2'b01;
      feed0.clause_last_i  = 1'b1;
      chk("l0_ready", feed0.clause_ready_o, 1);
      acc = cyc;
      @(negedge clk);
      feed0.clause_valid_i = 1'b0;
      chk("l0_valid_at_accept_plus1", feed0.res_valid_o, 0);
      @(negedge clk);
      chk("l0_latency_cycles", cyc - acc, 2);
      chk("l0_valid_at_accept_plus2", feed0.res_valid_o, 1);
      chk("l0_mask",  feed0.res_mask_o, 20'h00001);
      chk("l0_count", feed0.res_count_o, 1);
      chk("l0_fill",  feed0.res_fill_o, 1);
      $display("l0 batch accept cycle %0d mask=0x%05h count=%0d",
               acc, feed0.res_mask_o, feed0.res_count_o);
      feed0.res_ready_i = 1'b1;
      @(negedge clk);
      feed0.res_ready_i = 1'b0;
      chk("l0_valid_drop", feed0.res_valid_o, 0);
      chk("l0_ready_back", feed0.clause_ready_o, 1);
      chk("l0_var_val_padded", var_val0, {BW{1'b1}});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
